phase_shift_slewer: RTL and testbench

- Downstream consumer of the phase-shift calculator: an NCO phase accumulator that advances by `freq` every clock.
- On each new `phase_shift` result it applies that signed shift gradually over 2^SLEW_LOG2 clocks, so the total added is exactly `phase_shift` mod 2^32.
- Its output `phase_acc` drives the DDS/LUT stage.

---
 rtl/phase_shift_slewer.sv | 107 ++++++++++
 tb/tb_phase_shift_slewer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_shift_slewer.sv
// NCO phase accumulator that applies each new signed phase shift gradually,
// spreading it across 2^SLEW_LOG2 clocks on top of the per-clock frequency step.
module phase_shift_slewer #(
  parameter int SLEW_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] freq,
  input  logic        shift_ready,
  input  logic [31:0] phase_shift,
  input  logic        phase_load,
  input  logic [31:0] phase_init,
  output logic [31:0] phase_acc,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int CW = SLEW_LOG2 + 1;
  localparam logic [CW-1:0] SLEW_LEN = CW'(1) << SLEW_LOG2;
  localparam logic [31:0]   REM_MASK = (32'd1 << SLEW_LOG2) - 32'd1;

  typedef enum logic {IDLE, SLEW} state_t;

  state_t          state_q, state_next;
  logic [CW-1:0]   cnt_q, cnt_next;
  logic [31:0]     step_q, step_next;
  logic [31:0]     rem_q, rem_next;
  logic [31:0]     acc_next;
  logic [31:0]     slew_add;
  logic            ready_q;
  logic            req;
  logic            done_next;
  logic            overrun_next;

  assign req  = shift_ready & ~ready_q;
  assign busy = (state_q == SLEW);

  // The remainder rides on the final step so step*N + rem reproduces the shift exactly.
  always_comb begin
    slew_add = 32'd0;
    if (state_q == SLEW) begin
      if (cnt_q == CW'(1)) slew_add = step_q + rem_q;
      else                 slew_add = step_q;
    end
  end

  always_comb begin
    state_next   = state_q;
    cnt_next     = cnt_q;
    step_next    = step_q;
    rem_next     = rem_q;
    done_next    = 1'b0;
    overrun_next = 1'b0;
    acc_next     = phase_acc + freq + slew_add;

    if (phase_load) begin
      acc_next   = phase_init;
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            step_next  = 32'($signed(phase_shift) >>> SLEW_LOG2);
            rem_next   = phase_shift & REM_MASK;
            cnt_next   = SLEW_LEN;
            state_next = SLEW;
          end
        end
        SLEW: begin
          cnt_next     = cnt_q - CW'(1);
          overrun_next = req;
          if (cnt_q == CW'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ready_q resets high so a level already asserted at reset release is not a request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      step_q    <= '0;
      rem_q     <= '0;
      phase_acc <= '0;
      ready_q   <= 1'b1;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      step_q    <= step_next;
      rem_q     <= rem_next;
      phase_acc <= acc_next;
      ready_q   <= shift_ready;
      done      <= done_next;
      overrun   <= overrun_next;
    end
  end

endmodule

// File: tb/tb_phase_shift_slewer.sv
// Self-checking bench for phase_shift_slewer: table of shift vectors with a
// scoreboard of expected per-cycle phases, plus overrun and load-abort sequences.
module tb_phase_shift_slewer;

  localparam int SLEW_LOG2 = 4;
  localparam int N = 16;

  logic        clk;
  logic        reset;
  logic [31:0] freq;
  logic        shift_ready;
  logic [31:0] phase_shift;
  logic        phase_load;
  logic [31:0] phase_init;
  logic [31:0] phase_acc;
  logic        busy;
  logic        done;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] shift;
    logic [31:0] first;
    logic [31:0] final_acc;
  } vec_t;

  vec_t vecs[6];

  phase_shift_slewer #(.SLEW_LOG2(SLEW_LOG2)) dut (
    .clk(clk),
    .reset(reset),
    .freq(freq),
    .shift_ready(shift_ready),
    .phase_shift(phase_shift),
    .phase_load(phase_load),
    .phase_init(phase_init),
    .phase_acc(phase_acc),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkAcc(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, got 0x%08h", name, phase_acc);
    end else begin
      e = exp_q.pop_front();
      checkOutput(name, phase_acc, e);
    end
  endtask

  // Expected phase after each of the N slew edges, starting from zero with freq=0.
  task automatic pushSlew(input logic [31:0] first, input logic [31:0] final_acc);
    for (int i = 1; i < N; i++) exp_q.push_back(32'(i) * first);
    exp_q.push_back(final_acc);
  endtask

  task automatic startSlew(input string name, input logic [31:0] shift);
    phase_load  = 1'b1;
    phase_init  = 32'h0;
    freq        = 32'h0;
    shift_ready = 1'b0;
    tick();
    phase_load  = 1'b0;
    phase_shift = shift;
    shift_ready = 1'b1;
    tick();
    shift_ready = 1'b0;
    checkOutput({name, " accept busy"}, 32'(busy), 32'd1);
    checkOutput({name, " accept acc"}, phase_acc, 32'h0);
  endtask

  task automatic applyStimulus(input vec_t v);
    startSlew(v.name, v.shift);
    pushSlew(v.first, v.final_acc);
    for (int i = 1; i <= N; i++) begin
      tick();
      checkAcc($sformatf("%s acc step %0d", v.name, i));
      checkOutput($sformatf("%s busy step %0d", v.name, i), 32'(busy), (i < N) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s done step %0d", v.name, i), 32'(done), (i == N) ? 32'd1 : 32'd0);
    end
    tick();
    checkOutput({v.name, " done clears"}, 32'(done), 32'd0);
    checkOutput({v.name, " acc holds"}, phase_acc, v.final_acc);
  endtask

  initial begin
    int done_cnt;
    int ovr_cnt;

    vecs[0] = '{"pos19",   32'h00000013, 32'h00000001, 32'h00000013};
    vecs[1] = '{"neg15",   32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{"minint",  32'h80000000, 32'hF8000000, 32'h80000000};
    vecs[3] = '{"zero",    32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4] = '{"neg32",   32'hFFFFFFE0, 32'hFFFFFFFE, 32'hFFFFFFE0};
    vecs[5] = '{"maxpos",  32'h7FFFFFFF, 32'h07FFFFFF, 32'h7FFFFFFF};

    // Reset with random inputs, shift_ready held high through release
    reset       = 1'b0;
    freq        = $urandom;
    phase_shift = $urandom;
    phase_init  = $urandom;
    phase_load  = 1'b0;
    shift_ready = 1'b1;
    repeat (3) begin
      tick();
      freq        = $urandom;
      phase_shift = $urandom;
      phase_load  = 1'($urandom);
    end
    checkOutput("reset acc", phase_acc, 32'h0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    freq       = 32'h0;
    phase_load = 1'b0;
    reset      = 1'b1;
    #1;
    checkOutput("release done", 32'(done), 32'd0);
    checkOutput("release overrun", 32'(overrun), 32'd0);
    tick();
    checkOutput("post-reset busy", 32'(busy), 32'd0);
    checkOutput("post-reset acc", phase_acc, 32'h0);
    tick();
    checkOutput("post-reset busy2", 32'(busy), 32'd0);

    // Free run
    freq       = 32'h0147AE14;
    phase_load = 1'b1;
    phase_init = 32'h0;
    tick();
    phase_load = 1'b0;
    checkOutput("freerun load", phase_acc, 32'h0);
    repeat (200) tick();
    checkOutput("freerun 200", phase_acc, 32'hFFFFFFA0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Overrun at slew cycle 5 and at the cnt==1 edge
    startSlew("ovr", 32'h00000013);
    pushSlew(32'h1, 32'h13);
    done_cnt = 0;
    ovr_cnt  = 0;
    for (int i = 1; i <= N; i++) begin
      shift_ready = (i == 5 || i == 16);
      phase_shift = 32'h00000100;
      tick();
      checkAcc($sformatf("ovr acc step %0d", i));
      checkOutput($sformatf("ovr overrun step %0d", i), 32'(overrun), (i == 5 || i == 16) ? 32'd1 : 32'd0);
      if (done) done_cnt++;
      if (overrun) ovr_cnt++;
    end
    tick();
    if (done) done_cnt++;
    if (overrun) ovr_cnt++;
    checkOutput("ovr done count", 32'(done_cnt), 32'd1);
    checkOutput("ovr overrun count", 32'(ovr_cnt), 32'd2);
    checkOutput("ovr final acc", phase_acc, 32'h13);
    checkOutput("ovr idle", 32'(busy), 32'd0);

    // Load mid-slew with a coincident request
    startSlew("load", 32'h00000013);
    for (int i = 1; i <= 7; i++) exp_q.push_back(32'(i));
    for (int i = 1; i <= 7; i++) begin
      tick();
      checkAcc($sformatf("load acc step %0d", i));
    end
    phase_load  = 1'b1;
    phase_init  = 32'h40000000;
    shift_ready = 1'b1;
    tick();
    phase_load = 1'b0;
    checkOutput("load acc", phase_acc, 32'h40000000);
    checkOutput("load busy", 32'(busy), 32'd0);
    checkOutput("load done", 32'(done), 32'd0);
    checkOutput("load overrun", 32'(overrun), 32'd0);
    freq = 32'h00001000;
    for (int j = 1; j <= 10; j++) begin
      tick();
      checkOutput($sformatf("resume acc %0d", j), phase_acc, 32'h40000000 + 32'(j) * 32'h1000);
      checkOutput($sformatf("resume done %0d", j), 32'(done), 32'd0);
      checkOutput($sformatf("resume overrun %0d", j), 32'(overrun), 32'd0);
      checkOutput($sformatf("resume busy %0d", j), 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
